// File: rtl/product_accumulator_pkg.sv
// Shared widths and FSM state encodings for the product accumulator slice.
package product_accumulator_pkg;
   localparam int PW    = 8;
   localparam int ACC_W = 11;
   localparam int CNT_W = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/product_accumulator_if.sv
// Bus between a product source / result consumer (master) and the accumulator (slave).
// Handshakes: a product beat transfers on a rising clk edge where p_valid & p_ready (p_ready already
// includes ena); the result is offered while sum_valid is high and is taken by sum_ack in that state.
interface product_accumulator_if;
   import product_accumulator_pkg::*;

   logic             ena;
   logic             start;
   logic [CNT_W-1:0] num_terms;
   logic             p_valid;
   logic [PW-1:0]    p;
   logic             p_ready;
   logic [ACC_W-1:0] sum;
   logic             sum_valid;
   logic             sum_ack;
   logic             overflow;
   logic             busy;
   logic [1:0]       state_dbg;

   modport master (
      output ena, start, num_terms, p_valid, p, sum_ack,
      input  p_ready, sum, sum_valid, overflow, busy, state_dbg
   );

   modport slave (
      input  ena, start, num_terms, p_valid, p, sum_ack,
      output p_ready, sum, sum_valid, overflow, busy, state_dbg
   );
endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Combinational saturating adder: ACC_W-bit accumulator plus zero-extended PW-bit product.
module product_accumulator_sat_adder
   import product_accumulator_pkg::*;
(
   input  logic [ACC_W-1:0] a,
   input  logic [PW-1:0]    b,
   output logic [ACC_W-1:0] y,
   output logic             sat
);
   logic [ACC_W:0] full;

   always_comb begin
      full = {1'b0, a} + {{(ACC_W + 1 - PW){1'b0}}, b};
      sat  = full[ACC_W];
      y    = sat ? {ACC_W{1'b1}} : full[ACC_W-1:0];
   end
endmodule

// File: rtl/product_accumulator.sv
// Accumulates a programmed number of multiplier products into a saturating sum
// and offers the result to a consumer under a valid/ack handshake.
module product_accumulator
   import product_accumulator_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   product_accumulator_if.slave  bus
);
   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [ACC_W-1:0] add_y;
   logic             add_sat;

   product_accumulator_sat_adder u_sat_adder (
      .a   (acc_q),
      .b   (bus.p),
      .y   (add_y),
      .sat (add_sat)
   );

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      // With ena low nothing moves, so every update sits under this guard.
      if (bus.ena) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  acc_d      = '0;
                  overflow_d = 1'b0;
                  if (bus.num_terms != '0) begin
                     count_d = bus.num_terms;
                     state_d = ST_ACCUM;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_ACCUM: begin
               if (bus.p_valid) begin
                  acc_d      = add_y;
                  overflow_d = overflow_q | add_sat;
                  count_d    = count_q - CNT_W'(1);
                  if (count_q == CNT_W'(1)) state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.sum_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // acc is only cleared by start, so it doubles as the held result register.
   assign bus.sum       = acc_q;
   assign bus.sum_valid = (state_q == ST_DONE);
   assign bus.p_ready   = (state_q == ST_ACCUM) & bus.ena;
   assign bus.overflow  = overflow_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.state_dbg = state_q;
endmodule
